// File: rtl/mem_stage.sv
// Memory stage: data-memory load/store, jump resolution with timed flush, and WB registers.
// Optional post-reset memory clear is enabled by defining MEM_STAGE_CLEAR_EN.
module mem_stage #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       zeroIn,
  input  logic [7:0] aluVal,
  input  logic [7:0] jumpAddr,
  input  logic [7:0] rsVal,
  input  logic       WRMem,
  input  logic       WMMem,
  input  logic       RMMem,
  input  logic       NEQMem,
  input  logic       JMem,
  input  logic       JCMem,
  output logic [7:0] memVal,
  output logic [7:0] aluValWB,
  output logic       WRWB,
  output logic       RMWB,
  output logic       pcSrc,
  output logic [7:0] pcTarget,
  output logic       flush,
  output logic       stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [1:0]  FlushLoad = 2'(FLUSH_CYCLES);

  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_mem_val;
  logic [7:0]    r_alu_wb;
  logic          r_wr_wb;
  logic          r_rm_wb;
  logic          r_pc_src;
  logic [7:0]    r_pc_target;
  logic [1:0]    r_fcnt;
  logic          r_stall;

  logic          w_flush;
  logic          w_sq;
  logic          w_ewr;
  logic          w_ewm;
  logic          w_erm;
  logic          w_ej;
  logic          w_ejc;
  logic          w_taken;
  logic [AW-1:0] w_addr;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [7:0]    w_mem_wdata;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

  // Upper address bits are intentionally dropped when DEPTH < 256.
  logic unused_alu;
  assign unused_alu = ^aluVal;

  assign w_flush = (r_fcnt != 2'd0);
  assign w_sq    = w_flush | r_stall;
  assign w_ewr   = WRMem & ~w_sq;
  assign w_ewm   = WMMem & ~w_sq;
  assign w_erm   = RMMem & ~w_sq;
  assign w_ej    = JMem  & ~w_sq;
  assign w_ejc   = JCMem & ~w_sq;
  assign w_taken = w_ej | (w_ejc & (zeroIn ^ NEQMem));
  assign w_addr  = aluVal[AW-1:0];

`ifdef MEM_STAGE_CLEAR_EN
  typedef enum logic [0:0] {StIdle, StClear} clr_state_e;

  localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

  clr_state_e    r_state;
  logic          r_clr_pend;
  logic [AW-1:0] r_clr_addr;

  // Reset only arms the clear; the sweep starts once reset is released.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_clr_pend <= 1'b1;
      r_clr_addr <= '0;
      r_stall    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_clr_pend) begin
            r_state    <= StClear;
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
            r_stall    <= 1'b1;
          end
        end
        StClear: begin
          if (r_clr_addr == LastAddr) begin
            r_state <= StIdle;
            r_stall <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign w_clr_we   = (r_state == StClear) & ~reset;
  assign w_clr_addr = r_clr_addr;
`else
  assign r_stall    = 1'b0;
  assign w_clr_we   = 1'b0;
  assign w_clr_addr = '0;
`endif

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_addr;
    w_mem_wdata = rsVal;
    if (w_clr_we) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = w_clr_addr;
      w_mem_wdata = 8'h00;
    end else if (w_ewm && !reset) begin
      w_mem_we = 1'b1;
    end
  end

  // Storage has no reset; contents survive reset unless the clear sweep runs.
  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_val   <= 8'h00;
      r_alu_wb    <= 8'h00;
      r_wr_wb     <= 1'b0;
      r_rm_wb     <= 1'b0;
      r_pc_src    <= 1'b0;
      r_pc_target <= 8'h00;
      r_fcnt      <= 2'd0;
    end else begin
      // Non-blocking read returns pre-write contents on a same-cycle store.
      if (w_erm) begin
        r_mem_val <= r_mem[w_addr];
      end
      r_alu_wb <= aluVal;
      r_wr_wb  <= w_ewr;
      r_rm_wb  <= w_erm;
      if (w_taken) begin
        r_pc_src    <= 1'b1;
        r_pc_target <= jumpAddr;
        r_fcnt      <= FlushLoad;
      end else begin
        r_pc_src <= 1'b0;
        if (r_fcnt != 2'd0) begin
          r_fcnt <= r_fcnt - 2'd1;
        end
      end
    end
  end

  assign memVal   = r_mem_val;
  assign aluValWB = r_alu_wb;
  assign WRWB     = r_wr_wb;
  assign RMWB     = r_rm_wb;
  assign pcSrc    = r_pc_src;
  assign pcTarget = r_pc_target;
  assign flush    = w_flush;
  assign stall    = r_stall;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage (DEPTH=16) against a behavioural pipeline model.
// Covers the MEM_STAGE_CLEAR_EN build as well when that macro is defined.
module tb_mem_stage;

  localparam int Depth       = 16;
  localparam int FlushCycles = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       zeroIn;
  logic [7:0] aluVal;
  logic [7:0] jumpAddr;
  logic [7:0] rsVal;
  logic       WRMem, WMMem, RMMem, NEQMem, JMem, JCMem;
  logic [7:0] memVal, aluValWB, pcTarget;
  logic       WRWB, RMWB, pcSrc, flush, stall;

  mem_stage #(
    .DEPTH       (Depth),
    .FLUSH_CYCLES(FlushCycles)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .zeroIn  (zeroIn),
    .aluVal  (aluVal),
    .jumpAddr(jumpAddr),
    .rsVal   (rsVal),
    .WRMem   (WRMem),
    .WMMem   (WMMem),
    .RMMem   (RMMem),
    .NEQMem  (NEQMem),
    .JMem    (JMem),
    .JCMem   (JCMem),
    .memVal  (memVal),
    .aluValWB(aluValWB),
    .WRWB    (WRWB),
    .RMWB    (RMWB),
    .pcSrc   (pcSrc),
    .pcTarget(pcTarget),
    .flush   (flush),
    .stall   (stall)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: what each output should read after the last edge.
  logic [7:0] m_mem [Depth];
  bit         m_known [Depth];
  logic [7:0] m_memval;
  bit         m_mv_known;
  logic [7:0] m_alu;
  logic [7:0] m_tgt;
  bit         m_wr, m_rm, m_pc;
  int         m_fl;
  int         m_stall;
  bit         m_pend;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit sq, taken, ewm, erm;
    int a;
    if (reset) begin
      m_memval   = 8'h00;
      m_mv_known = 1'b1;
      m_alu      = 8'h00;
      m_tgt      = 8'h00;
      m_wr       = 1'b0;
      m_rm       = 1'b0;
      m_pc       = 1'b0;
      m_fl       = 0;
      m_stall    = 0;
`ifdef MEM_STAGE_CLEAR_EN
      m_pend     = 1'b1;
`endif
    end else begin
      sq    = (m_fl > 0) || (m_stall > 0);
      a     = int'(aluVal) % Depth;
      ewm   = WMMem && !sq;
      erm   = RMMem && !sq;
      taken = !sq && (JMem || (JCMem && (zeroIn != NEQMem)));
      if (erm) begin
        m_memval   = m_mem[a];
        m_mv_known = m_known[a];
      end
      if (ewm) begin
        m_mem[a]   = rsVal;
        m_known[a] = 1'b1;
      end
      m_alu = aluVal;
      m_wr  = WRMem && !sq;
      m_rm  = erm;
      m_pc  = taken;
      if (taken) m_tgt = jumpAddr;
      if (taken) m_fl = FlushCycles;
      else if (m_fl > 0) m_fl--;
      if (m_stall > 0) m_stall--;
      if (m_pend) begin
        m_pend  = 1'b0;
        m_stall = Depth;
        for (int i = 0; i < Depth; i++) begin
          m_mem[i]   = 8'h00;
          m_known[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    if (m_mv_known) check("memVal", memVal, m_memval);
    check("aluValWB", aluValWB, m_alu);
    check("WRWB", {7'd0, WRWB}, {7'd0, m_wr});
    check("RMWB", {7'd0, RMWB}, {7'd0, m_rm});
    check("pcSrc", {7'd0, pcSrc}, {7'd0, m_pc});
    check("pcTarget", pcTarget, m_tgt);
    check("flush", {7'd0, flush}, {7'd0, m_fl > 0});
    check("stall", {7'd0, stall}, {7'd0, m_stall > 0});
  endtask

  task automatic step(input bit rst, input bit wr, input bit wm, input bit rm, input bit neq,
                      input bit j, input bit jc, input bit z, input logic [7:0] alu,
                      input logic [7:0] jaddr, input logic [7:0] rs);
    reset    = rst;
    WRMem    = wr;
    WMMem    = wm;
    RMMem    = rm;
    NEQMem   = neq;
    JMem     = j;
    JCMem    = jc;
    zeroIn   = z;
    aluVal   = alu;
    jumpAddr = jaddr;
    rsVal    = rs;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < Depth; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b0;
    end
    m_pend     = 1'b0;
    m_mv_known = 1'b0;
    m_stall    = 0;
    m_fl       = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    step(1, 1, 1, 1, 0, 1, 0, 0, 8'h12, 8'h55, 8'h99);
    check("rst_memVal", memVal, 8'h00);
    check("rst_pcTarget", pcTarget, 8'h00);
    check("rst_flush", {7'd0, flush}, 8'h00);

`ifdef MEM_STAGE_CLEAR_EN
    // Clear sweep: a store issued mid-stall must be discarded.
    for (int c = 0; c < Depth; c++) begin
      if (c == 3) step(0, 1, 1, 0, 0, 0, 0, 0, 8'h05, 8'h00, 8'hEE);
      else nop();
      check("clr_stall_hi", {7'd0, stall}, 8'h01);
    end
    nop();
    check("clr_stall_lo", {7'd0, stall}, 8'h00);
    step(0, 0, 0, 1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h00);
    check("clr_load05", memVal, 8'h00);
`endif

    // Store then load same address.
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h12, 8'h00, 8'hA5);
    step(0, 1, 0, 1, 0, 0, 0, 0, 8'h12, 8'h00, 8'h00);
    check("ld_memVal", memVal, 8'hA5);
    check("ld_RMWB", {7'd0, RMWB}, 8'h01);
    check("ld_WRWB", {7'd0, WRWB}, 8'h01);

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < Depth; i++) begin
      step(0, 0, 1, 0, 0, 0, 0, 0, 8'(i), 8'h00, 8'(8'h80 + i));
    end

    // Conditional jump, branch-if-zero, taken.
    step(0, 0, 0, 0, 0, 0, 1, 1, 8'h00, 8'h40, 8'h00);
    check("jc_pcSrc", {7'd0, pcSrc}, 8'h01);
    check("jc_target", pcTarget, 8'h40);
    check("jc_flush1", {7'd0, flush}, 8'h01);
    nop();
    check("jc_pcSrc_pulse", {7'd0, pcSrc}, 8'h00);
    check("jc_flush2", {7'd0, flush}, 8'h01);
    nop();
    check("jc_flush_end", {7'd0, flush}, 8'h00);

    // Same but zeroIn=0: not taken.
    step(0, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h60, 8'h00);
    check("jcnt_pcSrc", {7'd0, pcSrc}, 8'h00);
    check("jcnt_flush", {7'd0, flush}, 8'h00);

    // Squash: store and jump during flush are ignored. 0x20 aliases word 0.
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h20, 8'h00, 8'h11);
    step(0, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h90, 8'h00);
    step(0, 0, 1, 0, 0, 1, 0, 0, 8'h20, 8'hC0, 8'h77);
    check("sq_pcSrc", {7'd0, pcSrc}, 8'h00);
    check("sq_target", pcTarget, 8'h90);
    nop();
    check("sq_flush_end", {7'd0, flush}, 8'h00);
    step(0, 0, 0, 1, 0, 0, 0, 0, 8'h20, 8'h00, 8'h00);
    check("sq_mem_kept", memVal, 8'h11);

    // Address wrap.
    step(0, 0, 1, 0, 0, 0, 0, 0, 8'h13, 8'h00, 8'h3C);
    step(0, 0, 0, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h00);
    check("wrap_memVal", memVal, 8'h3C);

    // Store+load same instruction returns the old contents.
    step(0, 0, 1, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h5A);
    check("rmw_old", memVal, 8'h3C);

    // Reset one cycle after a taken jump aborts the flush.
    step(0, 0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h77, 8'h00);
    step(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    check("rstfl_flush", {7'd0, flush}, 8'h00);
    check("rstfl_pcTarget", pcTarget, 8'h00);
    check("rstfl_memVal", memVal, 8'h00);
`ifdef MEM_STAGE_CLEAR_EN
    for (int c = 0; c < Depth; c++) nop();
`endif
    step(0, 1, 0, 1, 0, 0, 0, 0, 8'h03, 8'h00, 8'h00);
    check("rstfl_resume_RMWB", {7'd0, RMWB}, 8'h01);

    // Randomised traffic; resets drive idle controls.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(59) == 0) begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 8'(($urandom)), 8'h00, 8'h00);
      end else begin
        step(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(7) == 0), ($urandom_range(5) == 0), 1'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
